// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, state
// encoding and datapath select codes. Optional JAL support is enabled by
// defining RV_JAL_EN (see multicycle_ctrl.sv).
package rv_ctrl_pkg;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Sequencer states; the numeric value is exported on the State debug port
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Coarse ALU operation class handed to alu_dec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer (master) and the shared
// ALU/memory datapath (slave).
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        MemReq;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        Illegal;
  logic [3:0]  State;

  modport master (
    input  Instr, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the sequencer's coarse ALU class plus the instruction's
// funct fields onto a concrete ALU operation. Purely combinational.
module alu_dec
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] ALUControl
);

  // Select the ALU operation; unsupported funct3 values fall back to add
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (funct7b5 && op5) ALUControl = ALU_SUB;
            else                 ALUControl = ALU_ADD;
          end
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: Moore FSM that steps the shared datapath
// through fetch/decode/execute/memory/writeback and drives its selects and
// write enables. Fetch and memory states stall on MemReady.
// Optional feature macro: RV_JAL_EN (adds S_JAL for opcode 1101111; without
// it that opcode faults and the J immediate format is never selected).
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic       illegal;
  logic [6:0] opcode;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] alu_op;
  logic [3:0] alu_control;
  logic       unused_instr_bits;

  assign opcode            = bus.Instr[6:0];
  assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= state_t'(RESET_STATE);
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= illegal | (state_next == S_FAULT);
    end
  end

  // Next-state logic; memory states hold until MemReady
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.MemReady) state_next = S_DECODE;
        else              state_next = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
`ifdef RV_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default:      state_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) state_next = S_MEMWR;
        else                 state_next = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.MemReady) state_next = S_MEMWB;
        else              state_next = S_MEMRD;
      end
      S_MEMWB: state_next = S_FETCH;
      S_MEMWR: begin
        if (bus.MemReady) state_next = S_FETCH;
        else              state_next = S_MEMWR;
      end
      S_EXECR: state_next = S_ALUWB;
      S_EXECI: state_next = S_ALUWB;
      S_ALUWB: state_next = S_FETCH;
      S_BEQ:   state_next = S_FETCH;
`ifdef RV_JAL_EN
      S_JAL:   state_next = S_ALUWB;
`endif
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  // Moore output decode; everything defaults to idle/zero
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
      end
      S_DECODE: begin
        // Precompute OldPC + imm so a branch/jump target is ready in ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
`ifdef RV_JAL_EN
        if (opcode == OP_JAL) imm_src = IMM_J;
        else                  imm_src = IMM_B;
`endif
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_SW) imm_src = IMM_S;
        else                 imm_src = IMM_I;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
`ifdef RV_JAL_EN
      S_JAL: begin
        // ALUOut holds the jump target; the ALU forms OldPC+4 for rd
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        imm_src    = IMM_J;
      end
`endif
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  alu_dec u_alu_dec (
    .ALUOp      (alu_op),
    .funct3     (bus.Instr[14:12]),
    .funct7b5   (bus.Instr[30]),
    .op5        (bus.Instr[5]),
    .ALUControl (alu_control)
  );

  assign bus.MemReq     = mem_req;
  assign bus.MemWrite   = mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.Illegal    = illegal;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level reference model
// pushes one expected output record per cycle; a negedge monitor pops and
// compares against the DUT outputs.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, adr, irw, pcw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [3:0] alu;
    logic       ill;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  obs_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  logic ill_exp = 1'b0;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU operation an R-type instruction should select
  function automatic logic [3:0] ref_alu(logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (f3 == 3'd0)      return ins[30] ? 4'b0001 : 4'b0000;
    else if (f3 == 3'd7) return 4'b0010;
    else if (f3 == 3'd6) return 4'b0011;
    else                 return 4'b0000;
  endfunction

  // Expected outputs for one cycle spent in a given step of the sequence
  function automatic obs_t expect_step(state_t ph, logic rdy, logic zero,
                                       logic [31:0] ins, logic ill);
    obs_t e;
    e     = '0;
    e.st  = ph;
    e.ill = ill;
    case (ph)
      S_FETCH:  begin e.req = 1'b1; e.sb = 2'b10; e.res = 2'b10; e.irw = rdy; e.pcw = rdy; end
      S_DECODE: begin
        e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10;
`ifdef RV_JAL_EN
        if (ins[6:0] == 7'b1101111) e.imm = 2'b11;
`endif
      end
      S_MEMADR: begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (ins[6:0] == 7'b0100011) ? 2'b01 : 2'b00; end
      S_MEMRD:  begin e.req = 1'b1; e.adr = 1'b1; end
      S_MEMWB:  begin e.res = 2'b01; e.rw = 1'b1; end
      S_MEMWR:  begin e.req = 1'b1; e.wr = 1'b1; e.adr = 1'b1; end
      S_EXECR:  begin e.sa = 2'b10; e.sb = 2'b00; e.alu = ref_alu(ins); end
      S_EXECI:  begin e.sa = 2'b10; e.sb = 2'b01; e.imm = 2'b00; end
      S_ALUWB:  begin e.res = 2'b00; e.rw = 1'b1; end
      S_BEQ:    begin e.sa = 2'b10; e.sb = 2'b00; e.alu = 4'b0001; e.pcw = zero; end
      S_JAL:    begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; e.imm = 2'b11; end
      default:  begin e.req = 1'b0; end
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show in it
  task automatic cyc(state_t ph, logic rdy, logic zero, logic [31:0] ins, logic rst);
    bus.MemReady = rdy;
    bus.Zero     = zero;
    bus.Instr    = ins;
    reset        = rst;
    exp_q.push_back(expect_step(ph, rdy, zero, ins, ill_exp));
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from fetch to its last step. fw/mw are memory wait
  // cycles; rst_mid asserts reset during the first memory-wait cycle of a store.
  task automatic run_instr(logic [31:0] ins, logic zero, int fw, int mw, bit rst_mid);
    logic [6:0] op;
    op = ins[6:0];
    for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, 1'($urandom), ins, 1'b0);
    cyc(S_FETCH, 1'b1, 1'($urandom), ins, 1'b0);
    cyc(S_DECODE, 1'($urandom), 1'($urandom), ins, 1'b0);
    if (op == 7'b0000011) begin
      cyc(S_MEMADR, 1'($urandom), 1'($urandom), ins, 1'b0);
      for (int i = 0; i < mw; i++) cyc(S_MEMRD, 1'b0, 1'($urandom), ins, 1'b0);
      cyc(S_MEMRD, 1'b1, 1'($urandom), ins, 1'b0);
      cyc(S_MEMWB, 1'($urandom), 1'($urandom), ins, 1'b0);
    end else if (op == 7'b0100011) begin
      cyc(S_MEMADR, 1'($urandom), 1'($urandom), ins, 1'b0);
      if (rst_mid) begin
        cyc(S_MEMWR, 1'b0, 1'($urandom), ins, 1'b1);
      end else begin
        for (int i = 0; i < mw; i++) cyc(S_MEMWR, 1'b0, 1'($urandom), ins, 1'b0);
        cyc(S_MEMWR, 1'b1, 1'($urandom), ins, 1'b0);
      end
    end else if (op == 7'b0110011) begin
      cyc(S_EXECR, 1'($urandom), 1'($urandom), ins, 1'b0);
      cyc(S_ALUWB, 1'($urandom), 1'($urandom), ins, 1'b0);
    end else if (op == 7'b0010011) begin
      cyc(S_EXECI, 1'($urandom), 1'($urandom), ins, 1'b0);
      cyc(S_ALUWB, 1'($urandom), 1'($urandom), ins, 1'b0);
    end else if (op == 7'b1100011) begin
      cyc(S_BEQ, 1'($urandom), zero, ins, 1'b0);
`ifdef RV_JAL_EN
    end else if (op == 7'b1101111) begin
      cyc(S_JAL, 1'($urandom), 1'($urandom), ins, 1'b0);
      cyc(S_ALUWB, 1'($urandom), 1'($urandom), ins, 1'b0);
`endif
    end else begin
      ill_exp = 1'b1;
      for (int i = 0; i < 3; i++) cyc(S_FAULT, 1'($urandom), 1'($urandom), ins, 1'b0);
      cyc(S_FAULT, 1'($urandom), 1'($urandom), ins, 1'b1);
      ill_exp = 1'b0;
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    obs_t act;
    obs_t exp_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act = '{st: bus.State, req: bus.MemReq, wr: bus.MemWrite, adr: bus.AdrSrc,
              irw: bus.IRWrite, pcw: bus.PCWrite, rw: bus.RegWrite,
              res: bus.ResultSrc, sa: bus.ALUSrcA, sb: bus.ALUSrcB, imm: bus.ImmSrc,
              alu: bus.ALUControl, ill: bus.Illegal};
      vectors++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL step st=%0d instr=%h: got %h expected %h",
                 exp_v.st, bus.Instr, act, exp_v);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int          pick;
    reset        = 1'b1;
    bus.Instr    = 32'h0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;
    @(posedge clk);
    #1;
    // Reset held for two checked cycles with no MemReady
    cyc(S_FETCH, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(S_FETCH, 1'b0, 1'b0, 32'h0, 1'b1);

    // Directed cases
    run_instr(32'h002081B3, 1'b0, 0, 0, 1'b0);  // add x3,x1,x2
    run_instr(32'h00402283, 1'b0, 1, 3, 1'b0);  // lw x5,4(x0), 3 wait cycles
    run_instr(32'h00208463, 1'b1, 0, 0, 1'b0);  // beq taken
    run_instr(32'h00208463, 1'b0, 2, 0, 1'b0);  // beq not taken
    run_instr(32'h402081B3, 1'b0, 0, 0, 1'b0);  // sub
    run_instr(32'h0000007F, 1'b0, 0, 0, 1'b0);  // illegal opcode
    run_instr(32'h00112223, 1'b0, 0, 2, 1'b1);  // sw with reset mid-access
    run_instr(32'h00112223, 1'b0, 0, 1, 1'b0);  // sw completes
    run_instr(32'h008000EF, 1'b0, 0, 0, 1'b0);  // jal x1,8

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4:       op = 7'b0000011;
        5:       op = 7'b0100011;
        6:       op = 7'b1100011;
        7:       op = 7'b1101111;
        8:       op = 7'b1100111;
        default: op = 7'b0110111;
      endcase
      ins = {$urandom(), 7'b0};
      ins[6:0] = op;
      run_instr(ins, 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), (op == 7'b0100011) && ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
